// File: rtl/flac_pkg.sv
// Shared definitions for the residual encoder and its helpers: encoder FSM
// states, Rice/RAM constants and the signed-to-unsigned zigzag mapping.
package flac_pkg;

  localparam int unsigned RICE_PARAM_MAX = 14;
  localparam int unsigned RAM_WORD_W     = 16;

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StUnary,
    StTail,
    StFlush,
    StDone
  } enc_state_e;

  // Bitwise NOT of 2r equals -2r-1, so negatives need no adder.
  function automatic logic [16:0] zigzag(input logic [15:0] r);
    return r[15] ? ~{r, 1'b0} : {r, 1'b0};
  endfunction

endpackage

// File: rtl/bit_packer.sv
// MSB-first bit accumulator: appends up to 16 bits per cycle, emits 16-bit
// words to the RAM write port and pads out the final partial word on flush.
module bit_packer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              append_i,
  input  logic [15:0]       bits_i,
  input  logic [4:0]        nbits_i,
  input  logic              flush_i,
  output logic              flush_done_o,
  output logic              wren_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o
);

  logic [31:0]       buf_q, buf_d, shifted, bits_ext;
  logic [5:0]        cnt_q, cnt_d, cnt_rem, shamt;
  logic [ADDR_W-1:0] ptr_q, ptr_d, waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wren_q, emit;
  logic [16:0]       mask17;
  logic [15:0]       bits_masked;

  always_comb begin
    emit        = (cnt_q >= 6'd16) || (flush_i && (cnt_q != 6'd0));
    shifted     = emit ? {buf_q[15:0], 16'h0000} : buf_q;
    cnt_rem     = emit ? ((cnt_q >= 6'd16) ? cnt_q - 6'd16 : 6'd0) : cnt_q;
    mask17      = (17'd1 << nbits_i) - 17'd1;
    bits_masked = bits_i & mask17[15:0];
    // Remaining bits occupy the top cnt_rem positions; new bits go just below.
    shamt       = 6'd32 - cnt_rem - {1'b0, nbits_i};
    bits_ext    = {16'h0000, bits_masked} << shamt;
    buf_d       = shifted;
    cnt_d       = cnt_rem;
    ptr_d       = emit ? ptr_q + 1'b1 : ptr_q;
    if (append_i) begin
      buf_d = shifted | bits_ext;
      cnt_d = cnt_rem + {1'b0, nbits_i};
    end
    if (load_i) begin
      buf_d = '0;
      cnt_d = '0;
      ptr_d = start_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      wren_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      wren_q <= emit;
      if (emit) begin
        waddr_q <= ptr_q;
        wdata_q <= buf_q[31:16];
      end
    end
  end

  // At most 16 bits left means this cycle's emission empties the buffer.
  assign flush_done_o = flush_i && (cnt_q <= 6'd16);
  assign wren_o       = wren_q;
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;

endmodule

// File: rtl/rice_residual_encoder.sv
// Rice-codes a block of signed 16-bit residuals with a single parameter k and
// writes the packed MSB-first bitstream into the residual RAM.
module rice_residual_encoder
  import flac_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iEnable,
  input  logic [15:0]       iBlockSize,
  input  logic [4:0]        iRiceParam,
  input  logic [ADDR_W-1:0] iStartAddr,
  input  logic [15:0]       iResidual,
  input  logic              iValid,
  output logic              oReady,
  output logic [ADDR_W-1:0] oWriteAddr,
  output logic [DATA_W-1:0] oWriteData,
  output logic              oWren,
  output logic              oDone,
  output logic              oError
);

  enc_state_e  state_q;
  logic [3:0]  k_q;
  logic [15:0] size_q, smp_q;
  logic [16:0] qrem_q;
  logic [13:0] low_q;
  logic        done_q, error_q;

  logic [16:0] u_w, q_w;
  logic [13:0] low_mask, low_w;
  logic        k_legal, pk_load, pk_append, pk_flush, pk_flush_done;
  logic [15:0] pk_bits;
  logic [4:0]  pk_nbits;

  assign u_w      = zigzag(iResidual);
  assign q_w      = u_w >> k_q;
  assign low_mask = 14'((15'h1 << k_q) - 15'h1);
  assign low_w    = u_w[13:0] & low_mask;
  assign k_legal  = (iRiceParam <= 5'(RICE_PARAM_MAX));
  assign pk_load  = (state_q == StIdle) && iEnable && k_legal;
  assign pk_flush = (state_q == StFlush);

  always_comb begin
    pk_append = 1'b0;
    pk_bits   = '0;
    pk_nbits  = '0;
    case (state_q)
      StUnary: begin
        pk_append = 1'b1;
        pk_nbits  = (qrem_q >= 17'd16) ? 5'd16 : qrem_q[4:0];
      end
      StTail: begin
        // Terminating 1 of the unary code followed by the k low bits.
        pk_append = 1'b1;
        pk_bits   = (16'h0001 << k_q) | {2'b00, low_q};
        pk_nbits  = {1'b0, k_q} + 5'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= StIdle;
      k_q     <= '0;
      size_q  <= '0;
      smp_q   <= '0;
      qrem_q  <= '0;
      low_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (iEnable) begin
            if (k_legal) begin
              k_q     <= iRiceParam[3:0];
              size_q  <= iBlockSize;
              smp_q   <= '0;
              error_q <= 1'b0;
              state_q <= StAccept;
            end else begin
              error_q <= 1'b1;
            end
          end else begin
            error_q <= 1'b0;
          end
        end
        StAccept: begin
          if (iValid) begin
            qrem_q  <= q_w;
            low_q   <= low_w;
            smp_q   <= smp_q + 16'd1;
            state_q <= (q_w != 17'd0) ? StUnary : StTail;
          end
        end
        StUnary: begin
          qrem_q <= qrem_q - {12'h000, pk_nbits};
          if (qrem_q <= 17'd16) state_q <= StTail;
        end
        StTail: begin
          state_q <= (smp_q == size_q) ? StFlush : StAccept;
        end
        StFlush: begin
          if (pk_flush_done) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          if (!iEnable) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oReady = (state_q == StAccept);
  assign oDone  = done_q;
  assign oError = error_q;

  bit_packer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_bit_packer (
    .clk_i       (iClock),
    .rst_ni      (iReset),
    .load_i      (pk_load),
    .start_addr_i(iStartAddr),
    .append_i    (pk_append),
    .bits_i      (pk_bits),
    .nbits_i     (pk_nbits),
    .flush_i     (pk_flush),
    .flush_done_o(pk_flush_done),
    .wren_o      (oWren),
    .waddr_o     (oWriteAddr),
    .wdata_o     (oWriteData)
  );

endmodule

// File: tb/tb_rice_residual_encoder.sv
// Scoreboard bench: a bit-list Rice model predicts RAM writes, a monitor
// checks every write as it happens and a RAM image is read back per block.
module tb_rice_residual_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, valid;
  logic [15:0] blk_size, start_addr, residual;
  logic [4:0]  rice_k;
  logic        ready, wren, done, error;
  logic [15:0] waddr, wdata;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] ram [int];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          blk_writes = 0;

  always #5 clk = ~clk;

  rice_residual_encoder #(
    .ADDR_W(16),
    .DATA_W(16)
  ) dut (
    .iClock    (clk),
    .iReset    (rst_n),
    .iEnable   (en),
    .iBlockSize(blk_size),
    .iRiceParam(rice_k),
    .iStartAddr(start_addr),
    .iResidual (residual),
    .iValid    (valid),
    .oReady    (ready),
    .oWriteAddr(waddr),
    .oWriteData(wdata),
    .oWren     (wren),
    .oDone     (done),
    .oError    (error)
  );

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every RAM write is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && wren) begin
      ram[int'(waddr)] = wdata;
      blk_writes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", waddr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write", {8'h00, waddr, wdata}, {8'h00, e.addr, e.data});
      end
    end
  end

  // Reference: build the code as a flat bit list, then cut into padded words.
  task automatic model_block(input int k, input logic [15:0] start, input int rs[$],
                             output wr_t words[$]);
    bit bits[$];
    int u, q;
    words = {};
    foreach (rs[i]) begin
      u = (rs[i] >= 0) ? 2 * rs[i] : -2 * rs[i] - 1;
      q = u >> k;
      repeat (q) bits.push_back(1'b0);
      bits.push_back(1'b1);
      for (int b = k - 1; b >= 0; b--) bits.push_back(((u >> b) & 1) != 0);
    end
    while (bits.size() % 16 != 0) bits.push_back(1'b0);
    for (int w = 0; bits.size() > 0; w++) begin
      wr_t e;
      e.data = '0;
      for (int b = 0; b < 16; b++) e.data = {e.data[14:0], bits.pop_front()};
      e.addr = start + 16'(w);
      words.push_back(e);
    end
  endtask

  task automatic start_block(input int k, input logic [15:0] start, input int n);
    @(negedge clk);
    en         = 1'b1;
    rice_k     = 5'(k);
    blk_size   = 16'(n);
    start_addr = start;
    @(negedge clk);
    en = 1'b0;
  endtask

  // Drives one sample; returns the number of not-ready cycles that follow.
  task automatic drive_sample(input int r, input bit last, output int gap);
    int g;
    g = 0;
    while (!ready && g < 5000) begin
      g++;
      @(negedge clk);
    end
    check("ready_before_sample", 40'(ready), 40'd1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    valid    = 1'b1;
    residual = 16'(r);
    @(negedge clk);
    valid = 1'b0;
    gap   = 0;
    if (!last) begin
      while (!ready && gap < 5000) begin
        gap++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_block(input int k, input logic [15:0] start, input int rs[$]);
    wr_t words[$];
    int  gap, u, w;
    model_block(k, start, rs, words);
    foreach (words[i]) exp_q.push_back(words[i]);
    blk_writes = 0;
    start_block(k, start, rs.size());
    foreach (rs[i]) begin
      drive_sample(rs[i], i == rs.size() - 1, gap);
      if (i != rs.size() - 1) begin
        u = (rs[i] >= 0) ? 2 * rs[i] : -2 * rs[i] - 1;
        check("ready_gap", 40'(gap), 40'(((u >> k) + 15) / 16 + 1));
      end
    end
    w = 0;
    while (!done && w < 300) begin
      w++;
      @(negedge clk);
    end
    check("done_seen", 40'(done), 40'd1);
    @(negedge clk);
    check("scoreboard_drained", 40'(exp_q.size()), 40'd0);
    check("write_count", 40'(blk_writes), 40'(words.size()));
    foreach (words[i]) begin
      check("ram_readback", {8'h00, words[i].addr, ram[int'(words[i].addr)]},
            {8'h00, words[i].addr, words[i].data});
    end
    exp_q.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rs[$];
    int gap, k, n, lim, r;
    logic [15:0] st;
    wr_t dummy[$];

    rst_n = 1'b0; en = 1'b0; valid = 1'b0;
    blk_size = '0; start_addr = '0; residual = '0; rice_k = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {14'h0, ready, wren, done, error, waddr, wdata}, 40'd0);
    rst_n = 1'b1;
    @(negedge clk);

    rs = '{0, -1, 1};
    run_block(0, 16'h0100, rs);
    check("t1_word", 40'(ram[32'h0100]), 40'h0A400);
    check("t1_count", 40'(blk_writes), 40'd1);

    rs = '{5};
    run_block(2, 16'h0200, rs);
    check("t2_word", 40'(ram[32'h0200]), 40'h03000);
    rs = '{5, 0};
    run_block(2, 16'h0210, rs);

    rs = '{-20};
    run_block(0, 16'h0300, rs);
    check("t3_words", {ram[32'h0300], ram[32'h0301], 8'h00}, {16'h0000, 16'h0000, 8'h00});
    check("t3_last", 40'(ram[32'h0302]), 40'h00100);
    check("t3_count", 40'(blk_writes), 40'd3);
    rs = '{-20, 3};
    run_block(0, 16'h0310, rs);

    // Illegal k: no start, error held while enable stays high.
    @(negedge clk);
    en = 1'b1; rice_k = 5'd15; blk_size = 16'd4; start_addr = 16'h0400;
    repeat (3) @(negedge clk);
    check("err_high", 40'(error), 40'd1);
    check("err_not_ready", 40'(ready), 40'd0);
    rice_k = 5'd31;
    @(negedge clk);
    check("err_k31", 40'(error), 40'd1);
    en = 1'b0;
    @(negedge clk);
    check("err_clear", 40'(error), 40'd0);
    rs = '{7, -3};
    run_block(3, 16'h0400, rs);

    rs = {};
    repeat (16) rs.push_back(0);
    run_block(1, 16'h0500, rs);
    check("t5_words", {8'h00, ram[32'h0500], ram[32'h0501]}, {8'h00, 16'hAAAA, 16'hAAAA});
    check("t5_count", 40'(blk_writes), 40'd2);

    rs = '{-32768, 32767, 1};
    run_block(14, 16'hFFFF, rs);

    for (int t = 0; t < 10; t++) begin
      k   = $urandom_range(0, 14);
      n   = $urandom_range(1, 12);
      st  = (t % 3 == 0) ? 16'(16'hFFFE - $urandom_range(0, 2)) : 16'($urandom_range(0, 65535));
      lim = (k >= 11) ? 32767 : (1 << (k + 4));
      rs  = {};
      for (int i = 0; i < n; i++) begin
        r = int'($urandom_range(0, 2 * lim)) - lim;
        if (k >= 10 && $urandom_range(0, 9) == 0) r = -32768;
        rs.push_back(r);
      end
      run_block(k, st, rs);
    end

    // Reset in the middle of a long unary run.
    rs = '{-20000};
    model_block(0, 16'h0600, rs, dummy);
    foreach (dummy[i]) exp_q.push_back(dummy[i]);
    start_block(0, 16'h0600, 1);
    drive_sample(-20000, 1'b1, gap);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midblock_reset_outputs", {14'h0, ready, wren, done, error, waddr, wdata}, 40'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_writes_after_reset", 40'(wren), 40'd0);

    rs = '{0, -1, 1};
    run_block(0, 16'h0100, rs);
    check("restart_word", 40'(ram[32'h0100]), 40'h0A400);
    check("restart_count", 40'(blk_writes), 40'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rice_residual_encoder.md
Name: rice_residual_encoder

Overview:
- Encoder-side counterpart of the subframe residual decoder path.
- Accepts signed 16-bit residuals one at a time and Rice-codes them with a single fixed parameter k (one partition).
- Packs the resulting bitstream MSB-first into 16-bit words and writes them to the same dual-port RAM the decoder reads, using that RAM's write-port signals.
- Subframe and partition headers are written by a separate block; this block writes residual words only.

Parameters:
- ADDR_W, 16, width of the RAM write address.
- DATA_W, 16, RAM word width; the design is fixed at 16 and elaborates nothing else.

Ports:
- iClock  in  1  single clock; all logic on rising edge.
- iReset  in  1  asynchronous, active-low reset.
- iEnable  in  1  start request; sampled only in IDLE.
- iBlockSize  in  16  number of residuals in the block (1..65535).
- iRiceParam  in  5  Rice parameter k, legal range 0..14.
- iStartAddr  in  ADDR_W  RAM address of the first residual word.
- iResidual  in  16  signed residual.
- iValid  in  1  iResidual valid.
- oReady  out  1  block can accept iResidual this cycle.
- oWriteAddr  out  ADDR_W  RAM write address.
- oWriteData  out  16  RAM write data.
- oWren  out  1  RAM write enable.
- oDone  out  1  block fully written, including the padded final word.
- oError  out  1  illegal k requested.

Behaviour:
- Reset (iReset=0, asynchronous):
  - All outputs 0.
  - State IDLE; bit buffer, bit count and sample counter cleared.
  - Reset mid-block abandons the block; no further oWren until restarted.
- States: IDLE, ACCEPT, UNARY, TAIL, FLUSH, DONE.
- IDLE:
  - If iEnable=1 and k≤14: latch k, iBlockSize and iStartAddr; address pointer = iStartAddr; go to ACCEPT.
  - If iEnable=1 and k≥15: set oError=1 and stay IDLE. oError stays high while iEnable=1 and clears when iEnable=0.
- ACCEPT:
  - oReady=1 (combinational on state only).
  - On iValid=1: zigzag-map u = (r≥0) ? 2r : −2r−1, giving 17-bit unsigned u. Store q = u>>k and low = u[k−1:0].
  - Increment the sample counter.
  - Next state: UNARY if q>0, else TAIL.
  - iValid=0 holds ACCEPT.
- UNARY: each cycle append min(q_rem,16) zero bits and decrement q_rem. Go to TAIL when q_rem reaches 0. Duration is ceil(q/16) cycles.
- TAIL (one cycle):
  - Append a single 1 bit followed by the k bits of low, MSB first (1..15 bits).
  - If the sample counter equals the latched block size, go to FLUSH; else go to ACCEPT.
- Per-sample cost is 2 + ceil(q/16) cycles. oReady is low outside ACCEPT.
- Bit buffer (32 bits, MSB-aligned):
  - Whenever count ≥16 at a clock edge, the top 16 bits go to oWriteData with oWren=1 and oWriteAddr = pointer.
  - The buffer then shifts left by 16 and the pointer increments.
  - Emission and the append happen in the same cycle, so count stays ≤31 and never overflows.
  - Write latency is one cycle: the word appears on the edge after the cycle in which count reached 16.
- FLUSH:
  - Emit any complete words.
  - If 0<count<16, emit the remaining bits padded with zeros on the right as one final word.
  - Then go to DONE.
  - If count=0 after the complete words, no pad word is written.
- DONE: oDone=1 and no writes. Return to IDLE when iEnable=0.
- oWren is a single-cycle pulse per word; at most one word per cycle.
- Address wraps modulo 2^ADDR_W with no flag.
- iEnable is ignored outside IDLE/DONE, so it cannot abort a block mid-stream.

Decomposition:
- Shared package (flac_pkg): state encoding; constants RICE_PARAM_MAX=14 and RAM_WORD_W=16; a zigzag function for reuse by the parameter estimator.
- One natural sub-module: bit_packer. It owns the 32-bit buffer, the append of up to 16 bits per cycle, word emission, address pointer and flush/pad. Interface: bits, nbits, append, flush, iStartAddr, load, oWren/oWriteAddr/oWriteData, flush_done.
- The FSM, zigzag and quotient logic stay in the top module.

Test Plan:
- k=0, block size 3, residuals 0,−1,1, start address 0x0100:
  - Response: exactly one write of 0x0100←0xA400, then oDone=1.
- k=2, block size 1, residual 5:
  - u=10 gives bits 00110, written as a single word 0x3000.
  - Check oReady low for exactly 2 cycles (UNARY + TAIL).
- k=0, block size 1, residual −20:
  - u=39, so the stream is 39 zeros then 1.
  - Response: writes 0x0000, 0x0000, 0x0100 at consecutive addresses.
  - UNARY lasts 3 cycles.
- k=15 with iEnable=1:
  - Response: oError=1, no oWren, oReady=0.
  - After iEnable drops, oError=0 and a legal start works.
- k=1, block size 16, all residuals 0:
  - Each sample produces "10", 32 bits in total.
  - Response: two words 0xAAAA, 0xAAAA, and no pad word.
- Assert iReset=0 mid-UNARY:
  - Outputs go to 0 immediately; no later writes.
  - A restarted block reproduces the first scenario exactly.
- Bench behaviour: write into the RAM model, read back, and compare against a software bit-level reference model.
